// File: rtl/mw_writeback_pkg.sv
// Shared definitions for the writeback stage: opcodes, fixed destination
// registers, FSM state and write-data source encodings.
package mw_writeback_pkg;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    localparam logic [4:0] REG_RA      = 5'd31;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } wb_state_t;

    // Source of the pipeline write data
    typedef enum logic [1:0] {
        SEL_O,
        SEL_D,
        SEL_T
    } wb_sel_t;

endpackage

// File: rtl/mw_writeback_if.sv
// Multdiv completion bus: result delivery from the multdiv unit plus the
// writeback stage's occupancy/overrun status returned to it.
interface mw_writeback_if;
    logic        md_ready;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_busy;
    logic        md_overrun;

    modport master (
        output md_ready, md_result, md_rd,
        input  md_busy, md_overrun
    );

    modport slave (
        input  md_ready, md_result, md_rd,
        output md_busy, md_overrun
    );
endinterface

// File: rtl/wb_decode.sv
// Writeback instruction decode: which register the pipeline writes and
// where the data comes from. Writes targeting r0 are dropped here.
module wb_decode
    import mw_writeback_pkg::*;
(
    input  logic [4:0] ir_op,
    input  logic [4:0] ir_rd,
    output logic       pipe_we,
    output logic [4:0] pipe_rd,
    output wb_sel_t    sel
);

    logic       we_raw;
    logic [4:0] rd_raw;

    // Opcode to destination/source mapping
    always_comb begin
        we_raw = 1'b0;
        rd_raw = '0;
        sel    = SEL_O;
        case (ir_op)
            OP_ALU, OP_ADDI: begin
                we_raw = 1'b1;
                rd_raw = ir_rd;
            end
            OP_LW: begin
                we_raw = 1'b1;
                rd_raw = ir_rd;
                sel    = SEL_D;
            end
            OP_JAL: begin
                we_raw = 1'b1;
                rd_raw = REG_RA;
            end
            OP_SETX: begin
                we_raw = 1'b1;
                rd_raw = REG_RSTATUS;
                sel    = SEL_T;
            end
            default: ;
        endcase
    end

    assign pipe_we = we_raw && (rd_raw != '0);
    assign pipe_rd = rd_raw;

endmodule

// File: rtl/mw_writeback.sv
// Writeback stage: arbitrates the single register-file write port between
// pipeline writes and late multdiv results (1-entry pending buffer), keeps a
// registered copy of the last write for W->D bypass and requests a
// front-end freeze when a buffered multdiv result waits too long.
module mw_writeback
    import mw_writeback_pkg::*;
#(
    parameter int unsigned STALL_AFTER = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          o_in,
    input  logic [31:0]          d_in,
    input  logic [31:0]          ir_in,
    mw_writeback_if.slave        md,
    output logic                 rf_we,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_data,
    output logic                 byp_valid,
    output logic [4:0]           byp_rd,
    output logic [31:0]          byp_data,
    output logic                 fe_stall
);

    wb_state_t   state;
    logic [4:0]  buf_rd;
    logic [31:0] buf_data;
    logic [2:0]  wait_cnt;
    logic        overrun;

    logic        pipe_we;
    logic [4:0]  pipe_rd;
    wb_sel_t     pipe_sel;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        pending;

    wb_decode u_decode (
        .ir_op   (ir_in[31:27]),
        .ir_rd   (ir_in[26:22]),
        .pipe_we (pipe_we),
        .pipe_rd (pipe_rd),
        .sel     (pipe_sel)
    );

    // A multdiv result aimed at r0 is discarded outright
    assign md_valid = md.md_ready && (md.md_rd != '0);
    assign pending  = (state == ST_PENDING);

    // Pipeline write data source select
    always_comb begin
        pipe_data = o_in;
        case (pipe_sel)
            SEL_D:   pipe_data = d_in;
            SEL_T:   pipe_data = {5'b0, ir_in[26:0]};
            default: pipe_data = o_in;
        endcase
    end

    // Write-port arbitration: pipe, then buffer drain, then direct multdiv.
    // A new result arriving while PENDING replaces the buffer instead of
    // draining it, so the older result is never written.
    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        if (rst_n) begin
            if (pipe_we) begin
                rf_we   = 1'b1;
                rf_rd   = pipe_rd;
                rf_data = pipe_data;
            end else if (pending && !md_valid) begin
                rf_we   = 1'b1;
                rf_rd   = buf_rd;
                rf_data = buf_data;
            end else if (!pending && md_valid) begin
                rf_we   = 1'b1;
                rf_rd   = md.md_rd;
                rf_data = md.md_result;
            end
        end
    end

    // Pending-buffer FSM with wait counter and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            buf_rd   <= '0;
            buf_data <= '0;
            wait_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_valid && pipe_we) begin
                        buf_rd   <= md.md_rd;
                        buf_data <= md.md_result;
                        wait_cnt <= '0;
                        state    <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (md_valid) begin
                        buf_rd   <= md.md_rd;
                        buf_data <= md.md_result;
                        overrun  <= 1'b1;
                        if (wait_cnt != 3'd7)
                            wait_cnt <= wait_cnt + 3'd1;
                    end else if (!pipe_we) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt != 3'd7) begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // W->D bypass copy of the write performed this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_valid <= 1'b0;
            byp_rd    <= '0;
            byp_data  <= '0;
        end else begin
            byp_valid <= rf_we;
            byp_rd    <= rf_rd;
            byp_data  <= rf_data;
        end
    end

    assign md.md_busy    = pending;
    assign md.md_overrun = overrun;
    assign fe_stall      = pending && ({29'b0, wait_cnt} >= STALL_AFTER);

endmodule

// File: tb/tb_mw_writeback.sv
// Directed testbench for mw_writeback.
module tb_mw_writeback;

    logic        clk;
    logic        rst_n;
    logic [31:0] o_in;
    logic [31:0] d_in;
    logic [31:0] ir_in;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;
    logic        fe_stall;

    int unsigned n_checks;
    int unsigned n_errors;

    mw_writeback_if md_if ();

    mw_writeback #(.STALL_AFTER(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_in      (o_in),
        .d_in      (d_in),
        .ir_in     (ir_in),
        .md        (md_if),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .byp_valid (byp_valid),
        .byp_rd    (byp_rd),
        .byp_data  (byp_data),
        .fe_stall  (fe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns later
    task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] d,
                         input logic mdr, input logic [4:0] mrd, input logic [31:0] mres);
        ir_in             = ir;
        o_in              = o;
        d_in              = d;
        md_if.md_ready    = mdr;
        md_if.md_rd       = mrd;
        md_if.md_result   = mres;
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd, input logic [21:0] rest);
        return {op, rd, rest};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ir_in = '0; o_in = '0; d_in = '0;
        md_if.md_ready = 1'b0; md_if.md_rd = '0; md_if.md_result = '0;

        // Reset state
        repeat (2) step();
        drive(mk_ir(5'b00101, 5'd5, 22'd0), 32'h10, 32'h0, 1'b0, 5'd0, 32'h0);
        check("rst_rf_we", {31'b0, rf_we}, 32'd0);
        check("rst_byp_valid", {31'b0, byp_valid}, 32'd0);
        check("rst_md_busy", {31'b0, md_if.md_busy}, 32'd0);
        check("rst_fe_stall", {31'b0, fe_stall}, 32'd0);
        check("rst_overrun", {31'b0, md_if.md_overrun}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1. addi r5
        drive(mk_ir(5'b00101, 5'd5, 22'd0), 32'h10, 32'h0, 1'b0, 5'd0, 32'h0);
        check("addi_we", {31'b0, rf_we}, 32'd1);
        check("addi_rd", {27'b0, rf_rd}, 32'd5);
        check("addi_data", rf_data, 32'h10);
        step();

        // 2. lw r0, jal, setx, non-writing op
        drive(mk_ir(5'b01000, 5'd0, 22'd0), 32'h0, 32'h1234, 1'b0, 5'd0, 32'h0);
        check("byp_valid_addi", {31'b0, byp_valid}, 32'd1);
        check("byp_rd_addi", {27'b0, byp_rd}, 32'd5);
        check("byp_data_addi", byp_data, 32'h10);
        check("lw_r0_we", {31'b0, rf_we}, 32'd0);
        step();
        drive(mk_ir(5'b00011, 5'd0, 22'd5), 32'h40, 32'h0, 1'b0, 5'd0, 32'h0);
        check("byp_valid_lw_r0", {31'b0, byp_valid}, 32'd0);
        check("jal_we", {31'b0, rf_we}, 32'd1);
        check("jal_rd", {27'b0, rf_rd}, 32'd31);
        check("jal_data", rf_data, 32'h40);
        step();
        drive({5'b10101, 27'h7}, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0);
        check("setx_rd", {27'b0, rf_rd}, 32'd30);
        check("setx_data", rf_data, 32'h7);
        step();
        drive(mk_ir(5'b01000, 5'd12, 22'd0), 32'h0, 32'hCAFE0001, 1'b0, 5'd0, 32'h0);
        check("lw_rd", {27'b0, rf_rd}, 32'd12);
        check("lw_data", rf_data, 32'hCAFE0001);
        step();
        drive(mk_ir(5'b00010, 5'd9, 22'd0), 32'h55, 32'h0, 1'b0, 5'd0, 32'h0);
        check("other_op_we", {31'b0, rf_we}, 32'd0);
        step();

        // 3. md_ready on a nop: direct write
        drive(32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hDEAD);
        check("md_direct_we", {31'b0, rf_we}, 32'd1);
        check("md_direct_rd", {27'b0, rf_rd}, 32'd7);
        check("md_direct_data", rf_data, 32'hDEAD);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("md_direct_busy", {31'b0, md_if.md_busy}, 32'd0);
        check("md_direct_byp_rd", {27'b0, byp_rd}, 32'd7);
        step();

        // 4. md_ready collides with add r3
        drive(mk_ir(5'b00000, 5'd3, 22'd0), 32'h33, 32'h0, 1'b1, 5'd7, 32'hBEEF);
        check("coll_rd", {27'b0, rf_rd}, 32'd3);
        check("coll_data", rf_data, 32'h33);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("drain_busy", {31'b0, md_if.md_busy}, 32'd1);
        check("drain_rd", {27'b0, rf_rd}, 32'd7);
        check("drain_data", rf_data, 32'hBEEF);
        check("drain_stall", {31'b0, fe_stall}, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("after_drain_busy", {31'b0, md_if.md_busy}, 32'd0);
        check("after_drain_we", {31'b0, rf_we}, 32'd0);
        check("after_drain_byp", byp_data, 32'hBEEF);
        step();

        // 5. stall after waiting
        drive(mk_ir(5'b00101, 5'd1, 22'd0), 32'h1, 32'h0, 1'b1, 5'd9, 32'h99);
        step();
        drive(mk_ir(5'b00101, 5'd2, 22'd0), 32'h2, 32'h0, 1'b0, 5'd0, 32'h0);
        check("p1_stall", {31'b0, fe_stall}, 32'd0);
        check("p1_rd", {27'b0, rf_rd}, 32'd2);
        step();
        drive(mk_ir(5'b00101, 5'd3, 22'd0), 32'h3, 32'h0, 1'b0, 5'd0, 32'h0);
        check("p2_stall", {31'b0, fe_stall}, 32'd0);
        step();
        drive(mk_ir(5'b00101, 5'd4, 22'd0), 32'h4, 32'h0, 1'b0, 5'd0, 32'h0);
        check("p3_stall", {31'b0, fe_stall}, 32'd1);
        check("p3_rd", {27'b0, rf_rd}, 32'd4);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("p4_stall", {31'b0, fe_stall}, 32'd1);
        check("p4_rd", {27'b0, rf_rd}, 32'd9);
        check("p4_data", rf_data, 32'h99);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("post_stall", {31'b0, fe_stall}, 32'd0);
        check("post_busy", {31'b0, md_if.md_busy}, 32'd0);
        step();

        // 6. overrun, then reset mid-PENDING
        drive(mk_ir(5'b00101, 5'd1, 22'd0), 32'h1, 32'h0, 1'b1, 5'd10, 32'hA);
        step();
        drive(mk_ir(5'b00101, 5'd2, 22'd0), 32'h2, 32'h0, 1'b1, 5'd11, 32'hB);
        check("ovr_pipe_rd", {27'b0, rf_rd}, 32'd2);
        check("ovr_before", {31'b0, md_if.md_overrun}, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("ovr_set", {31'b0, md_if.md_overrun}, 32'd1);
        check("ovr_new_rd", {27'b0, rf_rd}, 32'd11);
        check("ovr_new_data", rf_data, 32'hB);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("ovr_sticky", {31'b0, md_if.md_overrun}, 32'd1);
        check("ovr_idle", {31'b0, md_if.md_busy}, 32'd0);
        step();
        drive(mk_ir(5'b00101, 5'd1, 22'd0), 32'h1, 32'h0, 1'b1, 5'd12, 32'hC);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("pre_rst_busy", {31'b0, md_if.md_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, rf_we}, 32'd0);
        check("rst_mid_busy", {31'b0, md_if.md_busy}, 32'd0);
        check("rst_mid_ovr", {31'b0, md_if.md_overrun}, 32'd0);
        check("rst_mid_byp", {31'b0, byp_valid}, 32'd0);
        check("rst_mid_stall", {31'b0, fe_stall}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rst_nodrain_we", {31'b0, rf_we}, 32'd0);
        step();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("rst_nodrain_byp", {31'b0, byp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
